// File: rtl/isa_bus_frontend.sv
// ISA I/O front end for the SM2201 board: synchronises IOR#/IOW#, decodes the
// 4-port window and holds the host with IOCHRDY until the automate reports rdy.
//
// state  | meaning
// IDLE   | waiting for a strobe falling edge
// ACTIVE | board selected, IOCHRDY low, waiting for rdy or timeout
// HOLD   | IOCHRDY released, waiting for the host to raise its strobe
// IGNORE | foreign, DMA or illegal cycle; wait for both strobes high

module isa_bus_frontend #(
   parameter logic [9:0] BASE_ADDR = 10'h300,
   parameter int         TIMEOUT   = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] isa_sa,
   input  logic       isa_aen,
   input  logic       isa_ior_n,
   input  logic       isa_iow_n,
   input  logic       rdy,
   output logic       sel,
   output logic       w,
   output logic [1:0] a,
   output logic       iochrdy,
   output logic       cycle_err
);

   typedef enum logic [1:0] {IDLE, ACTIVE, HOLD, IGNORE} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   logic       ior_m, ior_s, ior_p;
   logic       iow_m, iow_s, iow_p;
   logic [1:0] sync_vld;
   logic       armed;
   logic [7:0] cnt;

   logic       ior_fall, iow_fall, match, strobe_hi;

   // armed stays low until the synchronisers carry real pin levels and both
   // strobes have been seen high, so a strobe held low across reset is no edge
   assign ior_fall  = armed & ior_p & ~ior_s;
   assign iow_fall  = armed & iow_p & ~iow_s;
   assign match     = ~isa_aen & (isa_sa[9:2] == BASE_ADDR[9:2]);
   assign strobe_hi = w ? iow_s : ior_s;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         ior_m     <= 1'b1;
         ior_s     <= 1'b1;
         ior_p     <= 1'b1;
         iow_m     <= 1'b1;
         iow_s     <= 1'b1;
         iow_p     <= 1'b1;
         sync_vld  <= 2'b00;
         armed     <= 1'b0;
         cnt       <= 8'd0;
         sel       <= 1'b1;
         w         <= 1'b0;
         a         <= 2'b00;
         iochrdy   <= 1'b1;
         cycle_err <= 1'b0;
      end else begin
         ior_m     <= isa_ior_n;
         ior_s     <= ior_m;
         ior_p     <= ior_s;
         iow_m     <= isa_iow_n;
         iow_s     <= iow_m;
         iow_p     <= iow_s;
         sync_vld  <= {sync_vld[0], 1'b1};
         armed     <= armed | (sync_vld[1] & ior_s & iow_s);
         cycle_err <= 1'b0;

         case (state)
            IDLE: begin
               if ((ior_fall | iow_fall) && !ior_s && !iow_s) begin
                  cycle_err <= 1'b1;
                  state     <= IGNORE;
               end else if (ior_fall | iow_fall) begin
                  if (match) begin
                     a       <= isa_sa[1:0];
                     w       <= iow_fall;
                     sel     <= 1'b0;
                     iochrdy <= 1'b0;
                     cnt     <= 8'd0;
                     state   <= ACTIVE;
                  end else begin
                     state <= IGNORE;
                  end
               end
            end
            ACTIVE: begin
               // host abort takes precedence over completion and timeout
               if (strobe_hi) begin
                  sel     <= 1'b1;
                  iochrdy <= 1'b1;
                  state   <= IDLE;
               end else if (rdy) begin
                  iochrdy <= 1'b1;
                  state   <= HOLD;
               end else if (cnt == CNT_LAST) begin
                  iochrdy   <= 1'b1;
                  cycle_err <= 1'b1;
                  state     <= HOLD;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            HOLD: begin
               if (strobe_hi) begin
                  sel   <= 1'b1;
                  state <= IDLE;
               end
            end
            IGNORE: begin
               if (ior_s && iow_s) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_isa_bus_frontend.sv
// Bench for isa_bus_frontend: directed and randomised ISA cycles checked
// against expected waveforms derived from pin timing arithmetic.

module tb_isa_bus_frontend;

   localparam int         T    = 64;
   localparam logic [9:0] BASE = 10'h300;

   logic       clk;
   logic       reset;
   logic [9:0] isa_sa;
   logic       isa_aen;
   logic       isa_ior_n;
   logic       isa_iow_n;
   logic       rdy;
   logic       sel;
   logic       w;
   logic [1:0] a;
   logic       iochrdy;
   logic       cycle_err;

   int   n_cmp = 0;
   int   n_bad = 0;
   logic model_w;
   logic [1:0] model_a;

   isa_bus_frontend #(.BASE_ADDR(BASE), .TIMEOUT(T)) dut (
      .clk       (clk),
      .reset     (reset),
      .isa_sa    (isa_sa),
      .isa_aen   (isa_aen),
      .isa_ior_n (isa_ior_n),
      .isa_iow_n (isa_iow_n),
      .rdy       (rdy),
      .sel       (sel),
      .w         (w),
      .a         (a),
      .iochrdy   (iochrdy),
      .cycle_err (cycle_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, " sel"}, 32'(sel), 32'd1);
      check({tag, " iochrdy"}, 32'(iochrdy), 32'd1);
      check({tag, " cycle_err"}, 32'(cycle_err), 32'd0);
      check({tag, " w"}, 32'(w), 32'(model_w));
      check({tag, " a"}, 32'(a), 32'(model_a));
   endtask

   // r: rdy driven after clock r (0 = already high); s: strobe released after clock s
   task automatic run_cycle(input string name, input bit wr, input bit both,
                            input logic [9:0] addr, input bit aen, input int r, input int s);
      logic [9:0] base_v;
      bit   match;
      int   rseen, rel, endk, lowend;
      bit   tmo, err_exp;
      base_v  = BASE;
      match   = !both && !aen && (addr[9:2] == base_v[9:2]);
      rseen   = (r + 1 < 4) ? 4 : r + 1;
      tmo     = rseen > 3 + T;
      rel     = tmo ? 3 + T : rseen;
      endk    = s + 3;
      lowend  = (rel < endk) ? rel : endk;
      err_exp = match && tmo && (rel < endk);
      isa_sa  = addr;
      isa_aen = aen;
      if (r == 0) rdy = 1'b1;
      if (both) begin
         isa_ior_n = 1'b0;
         isa_iow_n = 1'b0;
      end else if (wr) begin
         isa_iow_n = 1'b0;
      end else begin
         isa_ior_n = 1'b0;
      end
      for (int k = 1; k <= s + 5; k++) begin
         tick();
         if (match && k == 3) begin
            model_w = wr;
            model_a = addr[1:0];
         end
         check($sformatf("%s sel k=%0d", name, k), 32'(sel),
               32'(!(match && k >= 3 && k < endk)));
         check($sformatf("%s iochrdy k=%0d", name, k), 32'(iochrdy),
               32'(!(match && k >= 3 && k < lowend)));
         check($sformatf("%s cycle_err k=%0d", name, k), 32'(cycle_err),
               32'((err_exp && k == rel) || (both && k == 3)));
         check($sformatf("%s w k=%0d", name, k), 32'(w), 32'(model_w));
         check($sformatf("%s a k=%0d", name, k), 32'(a), 32'(model_a));
         if (k == r) rdy = 1'b1;
         if (k == s) begin
            isa_ior_n = 1'b1;
            isa_iow_n = 1'b1;
         end
      end
      rdy = 1'b0;
   endtask

   initial begin
      reset     = 1'b0;
      isa_sa    = 10'h000;
      isa_aen   = 1'b0;
      isa_ior_n = 1'b1;
      isa_iow_n = 1'b1;
      rdy       = 1'b0;
      model_w   = 1'b0;
      model_a   = 2'b00;

      // reset hold with toggling strobes
      for (int i = 0; i < 4; i++) begin
         isa_sa    = 10'h302;
         isa_ior_n = 1'($urandom_range(0, 1));
         isa_iow_n = 1'($urandom_range(0, 1));
         tick();
         check_quiet($sformatf("reset_hold %0d", i));
      end
      isa_ior_n = 1'b1;
      isa_iow_n = 1'b1;
      tick();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) tick();

      run_cycle("wr302", 1'b1, 1'b0, 10'h302, 1'b0, 13, 20);
      run_cycle("rd301", 1'b0, 1'b0, 10'h301, 1'b0, 0, 6);
      run_cycle("miss310", 1'b0, 1'b0, 10'h310, 1'b0, 0, 6);
      run_cycle("dma300", 1'b1, 1'b0, 10'h300, 1'b1, 0, 6);
      run_cycle("timeout", 1'b1, 1'b0, 10'h300, 1'b0, 1000, T + 8);
      run_cycle("both", 1'b0, 1'b1, 10'h302, 1'b0, 0, 6);
      run_cycle("abort", 1'b0, 1'b0, 10'h303, 1'b0, 1000, 8);

      // reset during ACTIVE, strobe still low afterwards
      isa_sa    = 10'h302;
      isa_aen   = 1'b0;
      isa_iow_n = 1'b0;
      for (int k = 1; k <= 5; k++) tick();
      check("rst_mid pre sel", 32'(sel), 32'd0);
      reset = 1'b0;
      model_w = 1'b0;
      model_a = 2'b00;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_quiet($sformatf("rst_mid %0d", k));
      end
      reset = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         check_quiet($sformatf("post_rst_low %0d", k));
      end
      isa_iow_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check_quiet($sformatf("post_rst_rise %0d", k));
      end
      run_cycle("recover", 1'b1, 1'b0, 10'h301, 1'b0, 5, 12);

      for (int i = 0; i < 40; i++) begin
         bit         wr, both, aen;
         logic [9:0] addr;
         int         r, s;
         wr   = 1'($urandom_range(0, 1));
         both = ($urandom_range(0, 9) == 0);
         aen  = ($urandom_range(0, 4) == 0);
         addr = ($urandom_range(0, 1) == 1) ? (BASE | 10'($urandom_range(0, 3)))
                                            : 10'($urandom_range(0, 1023));
         r    = ($urandom_range(0, 5) == 0) ? 1000 : int'($urandom_range(0, 20));
         s    = ($urandom_range(0, 5) == 0) ? T + int'($urandom_range(0, 10))
                                            : int'($urandom_range(2, 30));
         run_cycle($sformatf("rnd%0d", i), wr, both, addr, aen, r, s);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "bench watchdog expired");
   end

endmodule

// File: doc/isa_bus_frontend.md
Name: isa_bus_frontend

Overview:
- Upstream stage of micro_program_automate in the SM2201 ISA–CAMAC interface board.
- Synchronises raw ISA I/O strobes, decodes the board's 4-port I/O window and presents sel/w/a to the automate.
- Holds the ISA cycle with IOCHRDY until the automate reports rdy, with timeout protection.

Parameters:
- BASE_ADDR, 10'h300, ISA I/O base address; bits [1:0] ignored, window is BASE_ADDR..BASE_ADDR+3.
- TIMEOUT, 64, clk cycles in ACTIVE without rdy before the cycle is forcibly released; legal range 2..255.

Ports:
- clk  in  1  system clock, single clock domain.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- isa_sa  in  10  ISA address SA[9:0], asynchronous.
- isa_aen  in  1  ISA AEN, 1 = DMA cycle, asynchronous.
- isa_ior_n  in  1  ISA IOR#, active-low, asynchronous.
- isa_iow_n  in  1  ISA IOW#, active-low, asynchronous.
- rdy  in  1  from micro_program_automate: 1 = requested operation complete.
- sel  out  1  to automate, active-low board select.
- w  out  1  to automate: 1 = write cycle, 0 = read cycle.
- a  out  2  to automate: port offset SA[1:0].
- iochrdy  out  1  ISA IOCHRDY: 0 = insert wait states, 1 = ready.
- cycle_err  out  1  one-clk pulse on timeout or illegal strobe combination.

Behaviour:
- Reset values: sel=1, w=0, a=2'b00, iochrdy=1, cycle_err=0, state IDLE, timeout counter 0, synchroniser and edge-history registers 1.
- Reset is honoured in any state, including mid-cycle; all outputs return to reset values at the reset clock edge.
- isa_ior_n and isa_iow_n each pass through a 2-FF synchroniser (ior_s, iow_s). A falling edge is ior_s=0 while the previous ior_s=1; iow_s is handled the same way.
- A strobe already low when reset deasserts produces no edge and is ignored until it rises.
- isa_sa and isa_aen are sampled in the cycle the falling edge is detected. ISA keeps them stable while the strobe is low.
- Match condition: isa_aen=0 and isa_sa[9:2]=BASE_ADDR[9:2].
- States:
  - IDLE:
    - Both strobes low in the same cycle (either one edging): cycle_err=1 for one clk, go IGNORE.
    - Edge with match: a<=isa_sa[1:0], w<=1 for an iow edge or 0 for an ior edge, sel<=0, iochrdy<=0, counter<=0, go ACTIVE. All are updated at the same edge.
    - Edge with no match: go IGNORE, outputs unchanged.
  - ACTIVE:
    - rdy=1: iochrdy<=1, go HOLD. If rdy is already 1 on the first ACTIVE cycle, iochrdy releases one clk after sel asserts.
    - rdy=0 and counter=TIMEOUT-1: iochrdy<=1, cycle_err<=1 (one clk), go HOLD.
    - Otherwise counter increments. Counter is 8 bits and never wraps, because of the range limit on TIMEOUT.
  - HOLD: when the active strobe's synchronised level returns to 1, sel<=1 and go IDLE. a and w are held until the next accepted cycle.
  - IGNORE: wait until ior_s=1 and iow_s=1, then go IDLE. sel stays 1.
- Strobe released during ACTIVE (host aborted): sel<=1, iochrdy<=1, go IDLE, no cycle_err.
- Edges arriving in ACTIVE, HOLD or IGNORE are not queued.
- Latency: pin falling edge to sel=0 is 3 clk (2 synchroniser + 1 register). rdy=1 to iochrdy=1 is 1 clk.

Test Plan:
- Reset hold: reset=0 for 4 clk while strobes toggle -> sel=1, w=0, a=0, iochrdy=1, cycle_err=0 throughout.
- Write to 0x302: isa_sa=10'h302, aen=0, iow_n falls; rdy goes 1 after 10 clk in ACTIVE.
  - sel=0 3 clk after the pin edge, w=1, a=2'b10, iochrdy=0.
  - iochrdy=1 one clk after rdy.
  - sel=1 3 clk after iow_n rises.
- Read from 0x301 with rdy already 1: sel=0, w=0, a=2'b01, iochrdy low for exactly 1 clk, no cycle_err.
- Non-matching and DMA cycles: address 0x310, then 0x300 with aen=1 -> sel stays 1, iochrdy stays 1 in both.
- Timeout: write to 0x300 with rdy held 0 -> iochrdy=0 for exactly 64 clk, then iochrdy=1 with a single-clk cycle_err=1; sel=1 after iow_n rises.
- Corner cases:
  - ior_n and iow_n fall together: cycle_err pulse, sel stays 1.
  - reset=0 asserted during ACTIVE: sel=1, iochrdy=1 at the next edge.
  - Strobe still low after reset deasserts: no cycle accepted.
